mux_n_to_1_skid: RTL

Parametrised N-input, W-bit selector with a registered, flow-controlled output stage for the datapath. The selected input word is captured on a valid/ready handshake into a two-entry skid buffer, so the select path is cut from downstream logic and stalls apply back-pressure without losing data. It serves as the registered successor to the fixed 3-to-1 32-bit select used at pipeline-stage boundaries, such as the forwarding and write-back selects.

---
 rtl/mux_pkg.sv | 23 ++
 rtl/skid_buffer.sv | 82 ++++++++
 rtl/mux_n_to_1_skid.sv | 63 ++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the registered N-to-1 select: default sizes, skid FSM
// state encoding and the select-width helper.
package mux_pkg;

  localparam int W_DEF = 32;
  localparam int N_DEF = 3;

  typedef logic [1:0] state_t;
  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

  // ceil(log2(n)) with a floor of one bit so a 2-input select still has a wire.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: main register drives the output, the skid
// register absorbs the one word that arrives while downstream stalls.
module skid_buffer
  import mux_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t       state_q, state_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         in_ready_q, in_ready_d;
  logic         in_xfer, out_xfer;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_data_q;
  assign in_ready  = in_ready_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          out_data_d = in_data;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          out_data_d = in_data;
        end else if (in_xfer) begin
          skid_data_d = in_data;
          state_d     = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          out_data_d = skid_data_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d     = ST_EMPTY;
      skid_data_d = '0;
    end
    // Registered ready is computed from the next state, so it never waits on out_ready.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: rtl/mux_n_to_1_skid.sv
// N-input W-bit select feeding a skid buffer. Defining MUX_SEL_CHECK_EN adds a
// sticky sel_err flag for out-of-range selects.
module mux_n_to_1_skid
  import mux_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int N     = N_DEF,
  parameter int SEL_W = sel_width(N)
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           flush,
  input  logic [N*W-1:0] in_data,
  input  logic [SEL_W-1:0] sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready
`ifdef MUX_SEL_CHECK_EN
  , output logic         sel_err
`endif
);

  logic [W-1:0] sel_word;

  // Out-of-range selects fall through to the last input, like the legacy default branch.
  always_comb begin
    sel_word = in_data[(N-1)*W +: W];
    for (int i = 0; i < N - 1; i++) begin
      if (sel == SEL_W'(i)) sel_word = in_data[i*W +: W];
    end
  end

  skid_buffer #(.W(W)) u_skid (
    .Clk       (Clk),
    .Reset     (Reset),
    .flush     (flush),
    .in_data   (sel_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

`ifdef MUX_SEL_CHECK_EN
  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);
  logic sel_err_q, sel_err_d;

  always_comb begin
    sel_err_d = sel_err_q | (in_valid & in_ready & ({1'b0, sel} >= N_EXT));
  end

  always_ff @(posedge Clk) begin
    if (Reset) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`endif

endmodule
